ifetch_buffer: RTL



---
 rtl/ifetch_buffer_pkg.sv | 16 +
 rtl/ifetch_buffer_if.sv | 29 ++
 rtl/ifetch_buffer_fifo_mem.sv | 67 ++++++
 rtl/ifetch_buffer.sv | 100 ++++++++++
 4 files changed

// File: rtl/ifetch_buffer_pkg.sv
// Shared fetch-bus constants and the response classification used by the fetch buffer.
package ifetch_buffer_pkg;

  localparam logic        RstEnable        = 1'b1;
  localparam int unsigned InstBusAddrWidth = 32;
  localparam int unsigned InstBusDataWidth = 32;
  localparam logic [InstBusDataWidth-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_FILL,
    RSP_DISCARD,
    RSP_ERROR
  } rsp_kind_e;

endpackage

// File: rtl/ifetch_buffer_if.sv
// PC-stage, instruction-memory and IF/ID signals of the fetch buffer.
interface ifetch_buffer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              stall_req;
  logic              flush;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [DATA_W-1:0] id_inst;

  modport master (
    input  pc, pc_valid, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data, id_ready,
    output stall_req, mem_req_valid, mem_req_addr, id_valid, id_pc, id_inst
  );

  modport slave (
    output pc, pc_valid, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data, id_ready,
    input  stall_req, mem_req_valid, mem_req_addr, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/ifetch_buffer_fifo_mem.sv
// In-order {pc, inst, filled} storage: entries allocated at request time, filled on response.
module ifetch_fifo_mem
  import ifetch_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W = InstBusAddrWidth,
  parameter int unsigned DATA_W = InstBusDataWidth,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] alloc_pc_i,
  input  logic              fill_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              pop_i,
  output logic              head_filled_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [DATA_W-1:0] head_inst_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]  filled_q;
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] inst_q [DEPTH];

  always_comb begin
    wr_ptr_d   = alloc_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    fill_ptr_d = fill_i  ? fill_ptr_q + 1'b1 : fill_ptr_q;
    rd_ptr_d   = pop_i   ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Alloc, fill and pop always address distinct slots, so the filled-bit writes never collide.
  always_ff @(posedge clk) begin
    if (rst == RstEnable || clear_i) begin
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      filled_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (alloc_i) begin
        pc_q[wr_ptr_q]     <= alloc_pc_i;
        filled_q[wr_ptr_q] <= 1'b0;
      end
      if (fill_i) begin
        inst_q[fill_ptr_q]   <= fill_data_i;
        filled_q[fill_ptr_q] <= 1'b1;
      end
      if (pop_i) begin
        filled_q[rd_ptr_q] <= 1'b0;
      end
    end
  end

  always_comb begin
    head_filled_o = filled_q[rd_ptr_q];
    head_pc_o     = pc_q[rd_ptr_q];
    head_inst_o   = inst_q[rd_ptr_q];
  end

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch stage: issues PC-stage addresses to instruction memory, buffers responses in order,
// and drops responses to fetches that were in flight when the pipeline flushed.
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W = InstBusAddrWidth,
  parameter int unsigned DATA_W = InstBusDataWidth,
  parameter int unsigned DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_buffer_if.master bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]  alloc_cnt_q, alloc_cnt_d;
  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;
  logic [CNT_W-1:0]  discard_cnt_q, discard_cnt_d;
  logic [CNT_W:0]    occupancy;
  logic              credit_ok, accept, fill, pop, id_valid;
  logic              head_filled;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_inst;
  rsp_kind_e         rsp_kind;

  always_comb begin
    occupancy         = {1'b0, alloc_cnt_q} + {1'b0, discard_cnt_q};
    credit_ok         = occupancy < (CNT_W+1)'(DEPTH);
    bus.mem_req_valid = bus.pc_valid & credit_ok & ~bus.flush & (rst != RstEnable);
    bus.mem_req_addr  = {bus.pc[ADDR_W-1:2], 2'b00};
    accept            = bus.mem_req_valid & bus.mem_req_ready;
    bus.stall_req     = ~accept;
  end

  always_comb begin
    rsp_kind = RSP_NONE;
    if (bus.mem_rsp_valid) begin
      if (discard_cnt_q != '0)     rsp_kind = RSP_DISCARD;
      else if (pend_cnt_q == '0)   rsp_kind = RSP_ERROR;
      else                         rsp_kind = RSP_FILL;
    end
  end

  always_comb begin
    fill         = (rsp_kind == RSP_FILL) & ~bus.flush;
    id_valid     = head_filled & (alloc_cnt_q != '0) & (rst != RstEnable);
    pop          = id_valid & bus.id_ready & ~bus.flush;
    bus.id_valid = id_valid;
    bus.id_pc    = id_valid ? head_pc : '0;
    bus.id_inst  = id_valid ? head_inst : '0;
  end

  // On flush every allocated-but-unfilled fetch still owes a response, minus the one arriving now.
  always_comb begin
    alloc_cnt_d   = alloc_cnt_q + CNT_W'(accept) - CNT_W'(pop);
    pend_cnt_d    = pend_cnt_q + CNT_W'(accept) - CNT_W'(fill);
    discard_cnt_d = discard_cnt_q;
    if (rsp_kind == RSP_DISCARD) discard_cnt_d = discard_cnt_q - 1'b1;
    if (bus.flush) begin
      alloc_cnt_d = '0;
      pend_cnt_d  = '0;
      if (rsp_kind == RSP_ERROR) discard_cnt_d = '0;
      else discard_cnt_d = discard_cnt_q + pend_cnt_q - CNT_W'(bus.mem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      alloc_cnt_q   <= '0;
      pend_cnt_q    <= '0;
      discard_cnt_q <= '0;
    end else begin
      alloc_cnt_q   <= alloc_cnt_d;
      pend_cnt_q    <= pend_cnt_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  ifetch_fifo_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (bus.flush),
    .alloc_i       (accept),
    .alloc_pc_i    (bus.pc),
    .fill_i        (fill),
    .fill_data_i   (bus.mem_rsp_data),
    .pop_i         (pop),
    .head_filled_o (head_filled),
    .head_pc_o     (head_pc),
    .head_inst_o   (head_inst)
  );

  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (rst == RstEnable)
                                     rsp_kind != RSP_ERROR);

endmodule
